// File: rtl/router_pkg.sv
// Shared definitions for the router packet source: header field widths,
// payload LFSR taps and the packet FSM state encoding.
package router_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam int DATA_W = 8;

  // x^8 + x^6 + x^5 + x^4 + 1 as a left-shifting Fibonacci tap mask (bits 7,5,4,3)
  localparam logic [DATA_W-1:0] LFSR_TAPS = 8'hB8;
  localparam logic [ADDR_W-1:0] ADDR_MAX  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PLD,
    ST_PAR,
    ST_GAP
  } state_e;

endpackage

// File: rtl/router_lfsr8.sv
// 8-bit Fibonacci LFSR used to generate packet payload bytes.
// An all-zero seed would lock the register, so it is replaced by 8'hFF on load.
module router_lfsr8
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              load,
  input  logic              enable,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] value
);

  logic [DATA_W-1:0] value_q;
  logic [DATA_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = (seed == '0) ? 8'hFF : seed;
    end else if (enable) begin
      value_d = {value_q[DATA_W-2:0], ^(value_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/router_pkt_src.sv
// Packet source for the router: sends header, LFSR payload and parity byte,
// honouring the router's busy stall, then idles GAP_CYCLES before accepting again.
module router_pkt_src
  import router_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [LEN_W-1:0]  payload_len,
  input  logic [DATA_W-1:0] seed,
  input  logic              corrupt_parity,
  input  logic              busy,
  output logic [DATA_W-1:0] data_in,
  output logic              pkt_valid,
  output logic              ready,
  output logic              done,
  output logic              cfg_err
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [DATA_W-1:0] parity_q, parity_d;
  logic              corrupt_q, corrupt_d;
  logic [3:0]        gap_q, gap_d;

  logic              lfsr_load;
  logic              lfsr_en;
  logic [DATA_W-1:0] lfsr_value;
  logic              cfg_legal;
  logic              xfer;

  assign cfg_legal = (dest_addr <= ADDR_MAX) && (payload_len != '0);
  assign xfer      = !busy;

  // The LFSR runs one byte ahead of data_in: its value is always the next
  // payload byte to present, so it steps whenever a byte moves into data_in.
  router_lfsr8 u_lfsr (
    .clock  (clock),
    .resetn (resetn),
    .load   (lfsr_load),
    .enable (lfsr_en),
    .seed   (seed),
    .value  (lfsr_value)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    remain_d  = remain_q;
    parity_d  = parity_q;
    corrupt_d = corrupt_q;
    gap_d     = gap_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_legal) begin
            state_d   = ST_HDR;
            data_d    = {payload_len, dest_addr};
            valid_d   = 1'b1;
            remain_d  = payload_len;
            corrupt_d = corrupt_parity;
            lfsr_load = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_HDR: begin
        if (xfer) begin
          state_d  = ST_PLD;
          data_d   = lfsr_value;
          parity_d = data_q;
          lfsr_en  = 1'b1;
        end
      end
      ST_PLD: begin
        if (xfer) begin
          parity_d = parity_q ^ data_q;
          remain_d = remain_q - 1'b1;
          if (remain_q == LEN_W'(1)) begin
            state_d = ST_PAR;
            data_d  = parity_q ^ data_q ^ {DATA_W{corrupt_q}};
            valid_d = 1'b0;
          end else begin
            data_d  = lfsr_value;
            lfsr_en = 1'b1;
          end
        end
      end
      ST_PAR: begin
        if (xfer) begin
          state_d = ST_GAP;
          data_d  = '0;
          done_d  = 1'b1;
          gap_d   = 4'(GAP_CYCLES - 1);
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        data_d  = '0;
        valid_d = 1'b0;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      remain_q  <= '0;
      parity_q  <= '0;
      corrupt_q <= 1'b0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      remain_q  <= remain_d;
      parity_q  <= parity_d;
      corrupt_q <= corrupt_d;
      gap_q     <= gap_d;
    end
  end

  assign data_in   = data_q;
  assign pkt_valid = valid_q;
  assign ready     = ready_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_router_pkt_src.sv
// Bench for router_pkt_src: directed and random packets compared byte by byte
// against an expected packet built from the header/payload/parity rules.
module tb_router_pkt_src;

  localparam int GAP = 2;

  logic       clock = 1'b0;
  logic       resetn;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] payload_len;
  logic [7:0] seed;
  logic       corrupt_parity;
  logic       busy;
  logic [7:0] data_in;
  logic       pkt_valid;
  logic       ready;
  logic       done;
  logic       cfg_err;

  int n_pass  = 0;
  int n_total = 0;

  router_pkt_src #(.GAP_CYCLES(GAP)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .start          (start),
    .dest_addr      (dest_addr),
    .payload_len    (payload_len),
    .seed           (seed),
    .corrupt_parity (corrupt_parity),
    .busy           (busy),
    .data_in        (data_in),
    .pkt_valid      (pkt_valid),
    .ready          (ready),
    .done           (done),
    .cfg_err        (cfg_err)
  );

  always #5 clock = ~clock;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Polynomial x^8+x^6+x^5+x^4+1, shifting towards the MSB.
  function automatic logic [7:0] prbs_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // mode: 0 no stall, 1 random busy, 2 busy toggling every cycle, 3 five-cycle stall at byte 8
  task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input logic [7:0] s,
                         input logic c, input int mode, input int abort_at);
    logic [7:0] exp_q[$];
    logic [7:0] x, acc, hdr;
    int idx, cyc, stall, total;
    logic b;
    bit aborted;

    hdr = {l, a};
    x   = (s == 8'h00) ? 8'hFF : s;
    acc = hdr;
    exp_q.push_back(hdr);
    for (int i = 0; i < int'(l); i++) begin
      exp_q.push_back(x);
      acc ^= x;
      x = prbs_next(x);
    end
    exp_q.push_back(c ? ~acc : acc);
    total = exp_q.size();

    chk1("ready_before_start", ready, 1'b1);
    start = 1'b1; dest_addr = a; payload_len = l; seed = s; corrupt_parity = c;
    busy = 1'b1;
    @(posedge clock); @(negedge clock);
    start = 1'b0;

    idx = 0; cyc = 0; stall = 0; aborted = 1'b0;
    while (idx < total && cyc < 400 && !aborted) begin
      chk8($sformatf("byte%0d", idx), data_in, exp_q[idx]);
      chk1($sformatf("valid%0d", idx), pkt_valid, idx < total - 1);
      chk1("ready_busy", ready, 1'b0);
      chk1("done_early", done, 1'b0);
      chk1("cfg_err_midpkt", cfg_err, 1'b0);
      if (idx == abort_at) begin
        #2 resetn = 1'b0;
        #1;
        chk8("rst_data", data_in, 8'h00);
        chk1("rst_valid", pkt_valid, 1'b0);
        chk1("rst_done", done, 1'b0);
        @(negedge clock);
        busy = 1'b0; start = 1'b0; resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(posedge clock); @(negedge clock);
          chk1("post_rst_ready", ready, 1'b1);
          chk1("post_rst_valid", pkt_valid, 1'b0);
          chk8("post_rst_data", data_in, 8'h00);
        end
        aborted = 1'b1;
      end else begin
        case (mode)
          1:       b = 1'($urandom);
          2:       b = 1'(cyc % 2 == 0);
          3:       b = (idx == 8 && stall < 5);
          default: b = 1'b0;
        endcase
        if (b) stall++;
        busy = b;
        // Junk start requests mid-packet must have no effect
        start = 1'($urandom); dest_addr = 2'($urandom); payload_len = 6'($urandom);
        seed = 8'($urandom); corrupt_parity = 1'($urandom);
        @(posedge clock); @(negedge clock);
        if (!b) idx++;
        cyc++;
      end
    end

    start = 1'b0;
    if (!aborted) begin
      chki("pkt_bytes_sent", idx, total);
      if (mode == 0) chki("busy_free_cycles", cyc, total);
      busy = 1'($urandom);
      chk1("done_pulse", done, 1'b1);
      chk8("gap_data", data_in, 8'h00);
      chk1("gap_valid", pkt_valid, 1'b0);
      chk1("gap_ready", ready, 1'b0);
      for (int k = 1; k < GAP; k++) begin
        busy = 1'($urandom);
        @(posedge clock); @(negedge clock);
        chk1("gap_done_low", done, 1'b0);
        chk1("gap_ready_low", ready, 1'b0);
      end
      @(posedge clock); @(negedge clock);
      chk1("ready_after_gap", ready, 1'b1);
      chk1("done_after_gap", done, 1'b0);
      busy = 1'b0;
    end
    $display("pkt addr=%0d len=%0d seed=%02h corrupt=%0b mode=%0d cycles=%0d%s",
             a, l, s, c, mode, cyc, aborted ? " aborted by reset" : "");
  endtask

  task automatic cfg_bad(input logic [1:0] a, input logic [5:0] l);
    start = 1'b1; dest_addr = a; payload_len = l; seed = 8'h11; corrupt_parity = 1'b0;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    chk1("cfg_err_pulse", cfg_err, 1'b1);
    chk1("cfg_err_valid", pkt_valid, 1'b0);
    chk1("cfg_err_ready", ready, 1'b1);
    @(posedge clock); @(negedge clock);
    chk1("cfg_err_single", cfg_err, 1'b0);
    chk1("cfg_err_valid2", pkt_valid, 1'b0);
    chk8("cfg_err_data", data_in, 8'h00);
    $display("cfg reject addr=%0d len=%0d", a, l);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; dest_addr = '0; payload_len = '0;
    seed = '0; corrupt_parity = 1'b0; busy = 1'b0;
    repeat (3) @(negedge clock);
    chk8("reset_data", data_in, 8'h00);
    chk1("reset_valid", pkt_valid, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk1("reset_cfg_err", cfg_err, 1'b0);
    resetn = 1'b1;
    @(negedge clock);
    chk1("reset_ready", ready, 1'b1);

    run_pkt(2'd1, 6'd14, 8'h5A, 1'b0, 0, -1);
    run_pkt(2'd1, 6'd20, 8'($urandom), 1'b0, 3, -1);
    cfg_bad(2'd3, 6'd5);
    cfg_bad(2'd1, 6'd0);
    cfg_bad(2'd3, 6'd0);
    run_pkt(2'd2, 6'd9, 8'($urandom), 1'b1, 0, -1);
    run_pkt(2'd0, 6'd12, 8'hC3, 1'b0, 1, 5);
    run_pkt(2'd0, 6'd7, 8'h3C, 1'b0, 0, -1);
    run_pkt(2'd2, 6'd1, 8'h00, 1'b0, 0, -1);
    run_pkt(2'd2, 6'd63, 8'($urandom), 1'b0, 2, -1);
    for (int p = 0; p < 10; p++) begin
      run_pkt(2'($urandom_range(2, 0)), 6'($urandom_range(63, 1)), 8'($urandom),
              1'($urandom), 1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
